// File: rtl/dht11_scheduler_pkg.sv
// Shared definitions for the DHT11 measurement scheduler: FSM state encoding
// and the millisecond divider helper.
package dht11_sched_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_FAIL  = 3'd3;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    WAIT  = ST_WAIT,
    FAIL  = ST_FAIL
  } sched_state_t;

  function automatic int ms_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/dht11_scheduler_ms_tick_gen.sv
// Millisecond tick: divider runs 0..ms_div(CLK_HZ)-1, tick is a registered
// one-cycle pulse on wrap.
module ms_tick_gen
  import dht11_sched_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = ms_div(CLK_HZ);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dht11_scheduler.sv
// DHT11 measurement scheduler: manual/auto start, minimum start spacing,
// timeout and checksum retries, last-good-sample hold.
module dht11_scheduler
  import dht11_sched_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PERIOD_MS  = 2000,
  parameter int MIN_GAP_MS = 1200,
  parameter int TIMEOUT_MS = 40,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       auto_en,
  input  logic       manual_req,
  output logic       dht_start,
  input  logic       dht_done,
  input  logic       dht_valid,
  input  logic [7:0] rh_in,
  input  logic [7:0] t_in,
  output logic [7:0] rh_data,
  output logic [7:0] t_data,
  output logic       data_valid,
  output logic       err,
  output logic       busy,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_out
);

  localparam int GW = $clog2(PERIOD_MS + 1);
  localparam int TW = $clog2(TIMEOUT_MS + 1);
  localparam logic [GW-1:0] PERIOD_V = GW'(PERIOD_MS);
  localparam logic [GW-1:0] GAP_V    = GW'(MIN_GAP_MS);
  localparam logic [TW-1:0] TO_V     = TW'(TIMEOUT_MS);
  localparam logic [1:0]    RETRY_V  = 2'(MAX_RETRY);

  sched_state_t  state;
  logic [GW-1:0] gap_ms;
  logic [TW-1:0] to_ms;
  logic          pend;
  logic          tick;
  logic          go_start;
  logic          tick_rst;

  always_comb begin
    go_start = (state == IDLE)
             && (pend || manual_req || (auto_en && gap_ms == PERIOD_V))
             && (gap_ms >= GAP_V);
    // Restarting the divider with each start makes gap_ms/to_ms count whole
    // milliseconds from the start pulse, so spacing never undershoots.
    tick_rst = rst | go_start;
  end

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (tick_rst),
    .tick (tick)
  );

  assign state_out = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gap_ms     <= '0;
      to_ms      <= '0;
      pend       <= 1'b0;
      dht_start  <= 1'b0;
      rh_data    <= '0;
      t_data     <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      retry_cnt  <= '0;
    end else begin
      dht_start <= 1'b0;
      if (tick && gap_ms != PERIOD_V) gap_ms <= gap_ms + 1'b1;
      if (manual_req) pend <= 1'b1;

      case (state)
        IDLE: begin
          if (go_start) begin
            state     <= START;
            dht_start <= 1'b1;
            busy      <= 1'b1;
            gap_ms    <= '0;
            pend      <= 1'b0;
          end
        end
        START: begin
          state <= WAIT;
          to_ms <= '0;
        end
        WAIT: begin
          if (dht_done) begin
            busy <= 1'b0;
            if (dht_valid) begin
              rh_data    <= rh_in;
              t_data     <= t_in;
              data_valid <= 1'b1;
              err        <= 1'b0;
              retry_cnt  <= '0;
              state      <= IDLE;
            end else begin
              state <= FAIL;
            end
          end else if (to_ms == TO_V) begin
            busy  <= 1'b0;
            state <= FAIL;
          end else if (tick) begin
            to_ms <= to_ms + 1'b1;
          end
        end
        FAIL: begin
          state <= IDLE;
          if (retry_cnt < RETRY_V) begin
            retry_cnt <= retry_cnt + 2'd1;
            pend      <= 1'b1;
          end else begin
            err       <= 1'b1;
            retry_cnt <= '0;
            // a fresh button press in this cycle still deserves a measurement
            if (!manual_req) pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
